trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter MPP_VAL, default 2'b11, privilege code written to mstatus.MPP on trap entry.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 valid_i  input  1  retiring instruction present; qualifies all event inputs.
REQ-005 pc_i  input  32  PC of the qualified instruction.
REQ-006 inst_i  input  32  instruction word of the qualified instruction.
REQ-007 badaddr_i  input  32  faulting address: branch target or load/store address.
REQ-008 exc_i  input  6  exception flags: bit0 inst misaligned, bit1 illegal, bit2 ebreak, bit3 ecall, bit4 load misaligned, bit5 store misaligned.
REQ-009 mret_i  input  1  qualified instruction is MRET.
REQ-010 irq_i  input  3  level interrupt lines {meip, mtip, msip}.
REQ-011 mstatus_i  input  32  current mstatus from the CSR file.
REQ-012 mie_i  input  32  current mie from the CSR file.
REQ-013 exc_ret_addr_i  input  32  CSR-file mux output: mtvec when sel_exc_nret_o=0, mepc when 1.
REQ-014 we_exc_o  output  1  one-cycle strobe; CSR file captures mcause/mepc/mtval.
REQ-015 mcause_d_o  output  32  cause value.
REQ-016 mepc_d_o  output  32  exception PC.
REQ-017 mtval_d_o  output  32  trap value.
REQ-018 mstatus_d_o  output  32  next mstatus.
REQ-019 mstatus_we_o  output  1  one-cycle strobe qualifying mstatus_d_o.
REQ-020 mip_d_o  output  32  registered pending-interrupt image.
REQ-021 sel_exc_nret_o  output  1  selects mepc (1) or mtvec (0) at the CSR file.
REQ-022 is_int_o  output  1  strobe with we_exc_o when the trap is an interrupt.
REQ-023 stall_o  output  1  freezes the pipeline while the FSM is not IDLE.
REQ-024 redirect_valid_o / redirect_pc_o  output  1 / 32  one-cycle fetch redirect plus flush; target address.

Function
REQ-025 The FSM SHALL have states IDLE, TRAP, RET, REDIR; events are sampled only in IDLE with valid_i=1; inputs in other states are ignored.
REQ-026 Priority SHALL be exception > interrupt > mret; exception order is bit0, bit1, bit2, bit3, bit4, bit5, with mcause 0, 2, 3, 11, 4, 6.
REQ-027 An interrupt SHALL be taken iff mstatus_i[3]=1 and (irq_i & {mie_i[11],mie_i[7],mie_i[3]}) != 0.
REQ-028 Interrupt priority SHALL be MEI > MSI > MTI; mcause = 0x8000000B, 0x80000003, 0x80000007 respectively.
REQ-029 On a taken trap in cycle N, the block SHALL register causes, enter TRAP at N+1 and drive we_exc_o=1, mstatus_we_o=1, is_int_o=1 if interrupt, and sel_exc_nret_o=0.
REQ-030 mepc_d_o SHALL be pc_i & 0xFFFFFFFC.
REQ-031 mtval_d_o SHALL be: badaddr_i for causes 0/4/6; inst_i for cause 2; pc_i for cause 3; 0 for cause 11 and interrupts.
REQ-032 Trap mstatus_d_o SHALL be mstatus_i with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=MPP_VAL.
REQ-033 When mret wins in cycle N, the FSM SHALL enter RET at N+1 with sel_exc_nret_o=1, mstatus_we_o=1, we_exc_o=0.
REQ-034 RET mstatus_d_o SHALL be mstatus_i with MIE[3]=MPIE[7] and MPIE[7]=1.
REQ-035 TRAP and RET SHALL both go to REDIR at N+2: redirect_valid_o=1, redirect_pc_o={exc_ret_addr_i[31:2],2'b00}, sel_exc_nret_o held; then IDLE at N+3.
REQ-036 stall_o SHALL be 1 in TRAP, RET and REDIR, 0 in IDLE; strobes SHALL be exactly one cycle wide.
REQ-037 mip_d_o SHALL equal irq_i mapped to bits 11/7/3 (zero elsewhere), registered every cycle regardless of state.

Reset
REQ-038 rst_i SHALL force IDLE immediately, including mid-sequence, with all outputs 0.
REQ-039 No redirect or strobe SHALL be issued for an event that was in flight when reset asserted.

Verification
REQ-040 exc_i=6'b000010, pc_i=0x100, inst_i=0xFFFFFFFF -> N+1: we_exc_o=1, mcause=2, mepc=0x100, mtval=0xFFFFFFFF; N+2: redirect to mtvec.
REQ-041 exc_i=6'b001001 (bits 0 and 3), badaddr_i=0x202 -> mcause=0, mtval=0x202.
REQ-042 irq_i=3'b100, mie_i[11]=1, mstatus_i=0x8 -> mcause=0x8000000B, is_int_o=1, mstatus_d_o=0x1880; with mstatus_i=0 -> no trap.
REQ-043 mret_i=1, mstatus_i=0x80, exc_ret_addr_i=0x400 -> mstatus_d_o=0x88, sel_exc_nret_o=1, redirect_pc_o=0x400 at N+2.
REQ-044 rst_i pulsed in TRAP -> all outputs 0 the same cycle; no redirect follows; a new event after release is taken normally.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Trap controller bus: retiring-instruction events and CSR-file views in, CSR
// write data, strobes and fetch redirect out.
interface trap_ctrl_if;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [31:0] badaddr_i;
    logic [5:0]  exc_i;
    logic        mret_i;
    logic [2:0]  irq_i;
    logic [31:0] mstatus_i;
    logic [31:0] mie_i;
    logic [31:0] exc_ret_addr_i;
    logic        we_exc_o;
    logic [31:0] mcause_d_o;
    logic [31:0] mepc_d_o;
    logic [31:0] mtval_d_o;
    logic [31:0] mstatus_d_o;
    logic        mstatus_we_o;
    logic [31:0] mip_d_o;
    logic        sel_exc_nret_o;
    logic        is_int_o;
    logic        stall_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    // Trap controller side.
    modport slave (
        input  valid_i, pc_i, inst_i, badaddr_i, exc_i, mret_i, irq_i,
               mstatus_i, mie_i, exc_ret_addr_i,
        output we_exc_o, mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o,
               mstatus_we_o, mip_d_o, sel_exc_nret_o, is_int_o, stall_o,
               redirect_valid_o, redirect_pc_o
    );

    // Pipeline / CSR-file side.
    modport master (
        output valid_i, pc_i, inst_i, badaddr_i, exc_i, mret_i, irq_i,
               mstatus_i, mie_i, exc_ret_addr_i,
        input  we_exc_o, mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o,
               mstatus_we_o, mip_d_o, sel_exc_nret_o, is_int_o, stall_o,
               redirect_valid_o, redirect_pc_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: picks exception > interrupt > mret from the
// retiring instruction, writes trap CSRs (or restores mstatus on mret), then
// redirects fetch to mtvec/mepc while stalling the pipeline.
module trap_ctrl #(
    parameter logic [1:0] MPP_VAL = 2'b11
) (
    input logic        clk_i,
    input logic        rst_i,
    trap_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, TRAP, RET, REDIR} state_t;

    state_t      state, next_state;
    logic [31:0] cause_q, mepc_q, mtval_q, mstatus_q, mip_q;
    logic        int_q, ret_q;

    logic        exc_hit, int_hit, take_trap, take_ret;
    logic [2:0]  int_pend;
    logic [31:0] cause_n, tval_n, trap_status, ret_status;

    // Low mie bits and the alignment bits of the return address are not needed.
    logic unused_bits;
    assign unused_bits = ^{bus.mie_i[31:12], bus.mie_i[10:8], bus.mie_i[6:4],
                           bus.mie_i[2:0], bus.exc_ret_addr_i[1:0]};

    // Event decode: prioritised cause, trap value and both mstatus images.
    always_comb begin
        exc_hit  = 1'b1;
        cause_n  = '0;
        tval_n   = '0;
        int_pend = bus.irq_i & {bus.mie_i[11], bus.mie_i[7], bus.mie_i[3]};
        int_hit  = bus.mstatus_i[3] && (int_pend != 3'b000);
        if (bus.exc_i[0]) begin
            cause_n = 32'd0;
            tval_n  = bus.badaddr_i;
        end else if (bus.exc_i[1]) begin
            cause_n = 32'd2;
            tval_n  = bus.inst_i;
        end else if (bus.exc_i[2]) begin
            cause_n = 32'd3;
            tval_n  = bus.pc_i;
        end else if (bus.exc_i[3]) begin
            cause_n = 32'd11;
        end else if (bus.exc_i[4]) begin
            cause_n = 32'd4;
            tval_n  = bus.badaddr_i;
        end else if (bus.exc_i[5]) begin
            cause_n = 32'd6;
            tval_n  = bus.badaddr_i;
        end else begin
            exc_hit = 1'b0;
            if (int_pend[2])      cause_n = 32'h8000_000B;
            else if (int_pend[0]) cause_n = 32'h8000_0003;
            else                  cause_n = 32'h8000_0007;
        end
        take_trap = bus.valid_i && (exc_hit || int_hit);
        take_ret  = bus.valid_i && bus.mret_i && !take_trap;

        trap_status        = bus.mstatus_i;
        trap_status[7]     = bus.mstatus_i[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = MPP_VAL;

        ret_status    = bus.mstatus_i;
        ret_status[3] = bus.mstatus_i[7];
        ret_status[7] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    // Next state: events only matter in IDLE; both paths funnel through REDIR.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (take_trap)     next_state = TRAP;
                else if (take_ret) next_state = RET;
            end
            TRAP, RET: next_state = REDIR;
            REDIR:     next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Capture trap/return data when an event is accepted; pending image every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cause_q   <= '0;
            mepc_q    <= '0;
            mtval_q   <= '0;
            mstatus_q <= '0;
            int_q     <= 1'b0;
            ret_q     <= 1'b0;
            mip_q     <= '0;
        end else begin
            mip_q <= {20'b0, bus.irq_i[2], 3'b0, bus.irq_i[1], 3'b0, bus.irq_i[0], 3'b0};
            if (state == IDLE && take_trap) begin
                cause_q   <= cause_n;
                mepc_q    <= {bus.pc_i[31:2], 2'b00};
                mtval_q   <= exc_hit ? tval_n : '0;
                mstatus_q <= trap_status;
                int_q     <= !exc_hit;
                ret_q     <= 1'b0;
            end else if (state == IDLE && take_ret) begin
                mstatus_q <= ret_status;
                int_q     <= 1'b0;
                ret_q     <= 1'b1;
            end
        end
    end

    // Outputs: strobes decoded from state, data straight from capture registers.
    always_comb begin
        bus.we_exc_o         = 1'b0;
        bus.mstatus_we_o     = 1'b0;
        bus.is_int_o         = 1'b0;
        bus.sel_exc_nret_o   = 1'b0;
        bus.stall_o          = 1'b0;
        bus.redirect_valid_o = 1'b0;
        bus.redirect_pc_o    = '0;
        bus.mcause_d_o       = cause_q;
        bus.mepc_d_o         = mepc_q;
        bus.mtval_d_o        = mtval_q;
        bus.mstatus_d_o      = mstatus_q;
        bus.mip_d_o          = mip_q;
        unique case (state)
            IDLE: ;
            TRAP: begin
                bus.we_exc_o     = 1'b1;
                bus.mstatus_we_o = 1'b1;
                bus.is_int_o     = int_q;
                bus.stall_o      = 1'b1;
            end
            RET: begin
                bus.mstatus_we_o   = 1'b1;
                bus.sel_exc_nret_o = 1'b1;
                bus.stall_o        = 1'b1;
            end
            REDIR: begin
                bus.redirect_valid_o = 1'b1;
                bus.redirect_pc_o    = {bus.exc_ret_addr_i[31:2], 2'b00};
                bus.sel_exc_nret_o   = ret_q;
                bus.stall_o          = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed events, a behavioural model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_trap_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    trap_ctrl_if bus ();
    trap_ctrl #(.MPP_VAL(2'b11)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 = CSR-write cycle, 2 = redirect cycle.
    int          phase = 0;
    bit          m_ret, m_int;
    logic [31:0] m_cause, m_epc, m_tval, m_status, m_mip;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0;
            m_mip = '0;
        end else begin
            automatic int unsigned codes[6] = '{0, 2, 3, 11, 4, 6};
            automatic bit found = 1'b0;
            automatic logic [31:0] s = bus.mstatus_i;
            automatic logic [2:0] pend;
            m_mip = '0;
            m_mip[11] = bus.irq_i[2];
            m_mip[7]  = bus.irq_i[1];
            m_mip[3]  = bus.irq_i[0];
            if (phase != 0) begin
                phase = (phase == 2) ? 0 : phase + 1;
            end else if (bus.valid_i) begin
                for (int i = 0; i < 6; i++) begin
                    if (bus.exc_i[i] && !found) begin
                        found   = 1'b1;
                        m_cause = codes[i];
                        m_int   = 1'b0;
                        if (codes[i] == 2)       m_tval = bus.inst_i;
                        else if (codes[i] == 3)  m_tval = bus.pc_i;
                        else if (codes[i] == 11) m_tval = 0;
                        else                     m_tval = bus.badaddr_i;
                    end
                end
                pend = bus.irq_i & {bus.mie_i[11], bus.mie_i[7], bus.mie_i[3]};
                if (!found && s[3] && pend != 0) begin
                    found  = 1'b1;
                    m_int  = 1'b1;
                    m_tval = 0;
                    if (pend[2])      m_cause = 32'h8000000B;
                    else if (pend[0]) m_cause = 32'h80000003;
                    else              m_cause = 32'h80000007;
                end
                if (found) begin
                    phase = 1;
                    m_ret = 1'b0;
                    m_epc = bus.pc_i & 32'hFFFF_FFFC;
                    m_status = s;
                    m_status[7] = s[3];
                    m_status[3] = 1'b0;
                    m_status[12:11] = 2'b11;
                end else if (bus.mret_i) begin
                    phase = 1;
                    m_ret = 1'b1;
                    m_int = 1'b0;
                    m_status = s;
                    m_status[3] = s[7];
                    m_status[7] = 1'b1;
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (checking) begin
            check("stall", 32'(bus.stall_o), 32'(phase != 0));
            check("we_exc", 32'(bus.we_exc_o), 32'(phase == 1 && !m_ret));
            check("mstatus_we", 32'(bus.mstatus_we_o), 32'(phase == 1));
            check("is_int", 32'(bus.is_int_o), 32'(phase == 1 && !m_ret && m_int));
            check("sel", 32'(bus.sel_exc_nret_o), 32'(phase != 0 && m_ret));
            check("redir_valid", 32'(bus.redirect_valid_o), 32'(phase == 2));
            check("redir_pc", bus.redirect_pc_o,
                  (phase == 2) ? (bus.exc_ret_addr_i & 32'hFFFF_FFFC) : 32'h0);
            check("mip", bus.mip_d_o, m_mip);
            if (phase == 1) begin
                check("mstatus_d", bus.mstatus_d_o, m_status);
                if (!m_ret) begin
                    check("mcause", bus.mcause_d_o, m_cause);
                    check("mepc", bus.mepc_d_o, m_epc);
                    check("mtval", bus.mtval_d_o, m_tval);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.valid_i = 1'b0; bus.pc_i = '0; bus.inst_i = '0; bus.badaddr_i = '0;
        bus.exc_i = '0; bus.mret_i = 1'b0; bus.irq_i = '0; bus.mstatus_i = '0;
        bus.mie_i = '0; bus.exc_ret_addr_i = 32'h0000_0083;
    endtask

    // Present the prepared event for one cycle; returns one step after the sampling edge.
    task automatic fire();
        bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
    endtask

    typedef struct { logic [5:0] exc; logic [2:0] irq; logic [31:0] mie; logic [31:0] mst; logic mret; } vec_t;
    vec_t vecs[$];

    initial begin
        clear();
        #1 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_stall", 32'(bus.stall_o), 0);
        check("rst_we", 32'(bus.we_exc_o), 0);
        check("rst_mcause", bus.mcause_d_o, 0);
        check("rst_mstatus", bus.mstatus_d_o, 0);
        checking = 1'b1;
        step();

        // Illegal instruction.
        bus.exc_i = 6'b000010; bus.pc_i = 32'h100; bus.inst_i = 32'hFFFF_FFFF;
        fire();
        bus.exc_i = '0;
        check("ill_we", 32'(bus.we_exc_o), 1);
        check("ill_mcause", bus.mcause_d_o, 32'd2);
        check("ill_mepc", bus.mepc_d_o, 32'h100);
        check("ill_mtval", bus.mtval_d_o, 32'hFFFF_FFFF);
        check("ill_sel", 32'(bus.sel_exc_nret_o), 0);
        step();
        check("ill_redir_v", 32'(bus.redirect_valid_o), 1);
        check("ill_redir_pc", bus.redirect_pc_o, 32'h80);
        step();
        check("ill_idle", 32'(bus.stall_o), 0);

        // Inst-misaligned beats ecall.
        clear();
        bus.exc_i = 6'b001001; bus.badaddr_i = 32'h202; bus.pc_i = 32'h207;
        fire();
        clear();
        check("mis_mcause", bus.mcause_d_o, 32'd0);
        check("mis_mtval", bus.mtval_d_o, 32'h202);
        check("mis_mepc", bus.mepc_d_o, 32'h204);
        step(); step();

        // Machine external interrupt.
        bus.irq_i = 3'b100; bus.mie_i = 32'h800; bus.mstatus_i = 32'h8; bus.pc_i = 32'h40;
        fire();
        check("mei_mcause", bus.mcause_d_o, 32'h8000_000B);
        check("mei_is_int", 32'(bus.is_int_o), 1);
        check("mei_mstatus", bus.mstatus_d_o, 32'h1880);
        check("mei_mtval", bus.mtval_d_o, 32'h0);
        step(); step();
        // Same interrupt with MIE clear: nothing happens.
        bus.mstatus_i = 32'h0;
        fire();
        check("mei_off_stall", 32'(bus.stall_o), 0);
        check("mei_off_we", 32'(bus.we_exc_o), 0);
        clear();
        step();

        // mret.
        bus.mret_i = 1'b1; bus.mstatus_i = 32'h80; bus.exc_ret_addr_i = 32'h400;
        fire();
        check("ret_mstatus", bus.mstatus_d_o, 32'h88);
        check("ret_sel", 32'(bus.sel_exc_nret_o), 1);
        check("ret_we_exc", 32'(bus.we_exc_o), 0);
        step();
        check("ret_redir_pc", bus.redirect_pc_o, 32'h400);
        check("ret_redir_sel", 32'(bus.sel_exc_nret_o), 1);
        clear();
        step();

        // Priority sweep checked by the model.
        vecs.push_back('{6'b000100, 3'b000, 32'h0,   32'h8,  1'b0});
        vecs.push_back('{6'b001000, 3'b000, 32'h0,   32'h0,  1'b0});
        vecs.push_back('{6'b110000, 3'b000, 32'h0,   32'h0,  1'b0});
        vecs.push_back('{6'b100000, 3'b111, 32'h888, 32'h8,  1'b1});
        vecs.push_back('{6'b000000, 3'b011, 32'h888, 32'h8,  1'b0});
        vecs.push_back('{6'b000000, 3'b110, 32'h080, 32'h88, 1'b0});
        vecs.push_back('{6'b000000, 3'b101, 32'h008, 32'h8,  1'b1});
        vecs.push_back('{6'b000000, 3'b100, 32'h888, 32'h0,  1'b1});
        vecs.push_back('{6'b000000, 3'b000, 32'h0,   32'h0,  1'b0});
        foreach (vecs[i]) begin
            bus.exc_i = vecs[i].exc; bus.irq_i = vecs[i].irq; bus.mie_i = vecs[i].mie;
            bus.mstatus_i = vecs[i].mst; bus.mret_i = vecs[i].mret;
            bus.pc_i = 32'h1000 + 32'(i) * 32'h11; bus.inst_i = 32'hA5A5_0000 + 32'(i);
            bus.badaddr_i = 32'hB000 + 32'(i); bus.exc_ret_addr_i = 32'h2000 + 32'(i);
            fire();
            step(); step();
        end
        clear();

        // Event present without valid is ignored.
        bus.exc_i = 6'b000010;
        step();
        check("novalid_stall", 32'(bus.stall_o), 0);
        clear();

        // Valid held through TRAP with a new event: must not retrigger.
        bus.exc_i = 6'b001000; bus.valid_i = 1'b1;
        step();
        bus.exc_i = 6'b000010;
        step();
        bus.valid_i = 1'b0;
        step();
        check("hold_idle", 32'(bus.stall_o), 0);
        clear();

        // Reset in TRAP.
        bus.exc_i = 6'b000010; bus.pc_i = 32'h300;
        fire();
        clear();
        rst = 1'b1;
        #1;
        check("rst_mid_we", 32'(bus.we_exc_o), 0);
        check("rst_mid_stall", 32'(bus.stall_o), 0);
        check("rst_mid_mcause", bus.mcause_d_o, 0);
        check("rst_mid_mstatus_we", 32'(bus.mstatus_we_o), 0);
        step();
        rst = 1'b0;
        check("rst_no_redir", 32'(bus.redirect_valid_o), 0);
        step();
        check("rst_no_redir2", 32'(bus.redirect_valid_o), 0);
        bus.exc_i = 6'b000100; bus.pc_i = 32'h508;
        fire();
        clear();
        check("post_rst_we", 32'(bus.we_exc_o), 1);
        check("post_rst_mcause", bus.mcause_d_o, 32'd3);
        check("post_rst_mtval", bus.mtval_d_o, 32'h508);
        step(); step(); step();

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
